// File: rtl/sm_seq_divider.sv
// Sequential sign-magnitude divider: 2N-bit dividend / N-bit divisor,
// restoring shift-subtract, one quotient bit per clock.
// Optional build macro SM_DIV_OPCOUNT_EN adds an 8-bit completion counter
// output op_count (wraps at 255).
// Requires N >= 3.
module sm_seq_divider #(
  parameter int N = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic           overflow
`ifdef SM_DIV_OPCOUNT_EN
  ,
  output logic [7:0]     op_count
`endif
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIN
  } state_t;

  state_t state, state_nxt;

  logic [N-2:0]  prem;     // partial remainder, always below the divisor magnitude
  logic [N-2:0]  lo;       // remaining dividend low bits; quotient bits shift in at the bottom
  logic [N-2:0]  dmag;
  logic [CW-1:0] cnt;
  logic          dsign;
  logic          vsign;

  logic          dz;
  logic          ov;
  logic [N-1:0]  shifted;
  logic          take;
  logic [N-2:0]  diff;

  assign dz      = (divisor[N-2:0] == '0);
  assign ov      = (dividend[2*N-2:N-1] >= {1'b0, divisor[N-2:0]});
  // N-bit trial keeps the bit shifted out of the partial remainder
  assign shifted = {prem, lo[N-2]};
  assign take    = (shifted >= {1'b0, dmag});
  assign diff    = (N-1)'(shifted - {1'b0, dmag});

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (dz || ov) ? FIN : DIV;
      DIV:  if (cnt == CW'(1)) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath, result registers and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      prem        <= '0;
      lo          <= '0;
      dmag        <= '0;
      cnt         <= '0;
      dsign       <= 1'b0;
      vsign       <= 1'b0;
`ifdef SM_DIV_OPCOUNT_EN
      op_count    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dsign       <= dividend[2*N-1];
            vsign       <= divisor[N-1];
            dmag        <= divisor[N-2:0];
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (dz) begin
              div_by_zero <= 1'b1;
              quotient    <= '0;
              remainder   <= '0;
            end else if (ov) begin
              overflow    <= 1'b1;
              quotient    <= '0;
              remainder   <= '0;
            end else begin
              busy <= 1'b1;
              cnt  <= CW'(N-1);
              prem <= dividend[2*N-3:N-1];
              lo   <= dividend[N-2:0];
            end
          end
        end
        DIV: begin
          prem <= take ? diff : shifted[N-2:0];
          lo   <= {lo[N-3:0], take};
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) busy <= 1'b0;
        end
        FIN: begin
          done <= 1'b1;
          if (!div_by_zero && !overflow) begin
            quotient  <= {(lo != '0) & (dsign ^ vsign), lo};
            remainder <= {(prem != '0) & dsign, prem};
          end
`ifdef SM_DIV_OPCOUNT_EN
          op_count <= op_count + 8'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sm_seq_divider.md
Name: sm_seq_divider

Overview:
- Sequential sign-magnitude binary divider; the inverse datapath of the lab's sign-magnitude multiplier.
- Divides a 2N-bit sign-magnitude dividend (multiplier-product format) by an N-bit sign-magnitude divisor.
- Returns an N-bit sign-magnitude quotient and an N-bit sign-magnitude remainder.
- Restoring shift-subtract algorithm, one quotient bit per clock, with a start/busy/done handshake.

Parameters:
- N, default 6: operand width. Divisor, quotient and remainder are N bits; dividend is 2N bits; the MSB of each is the sign.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  2N  sign-magnitude dividend; bit 2N-1 is the sign, bits 2N-2:0 the magnitude.
- divisor  input  N  sign-magnitude divisor; bit N-1 is the sign, bits N-2:0 the magnitude.
- quotient  output  N  sign-magnitude quotient.
- remainder  output  N  sign-magnitude remainder.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when results are valid.
- div_by_zero  output  1  divisor magnitude was zero.
- overflow  output  1  quotient magnitude does not fit in N-1 bits.

Behaviour:
- Reset:
  - Taken only on a clk edge with rst=1. The FSM goes to IDLE.
  - quotient, remainder, busy, done, div_by_zero and overflow all go to 0.
  - rst has priority over every other event, including mid-operation. An interrupted division produces no done.
- States: IDLE, DIV, FIN.
- IDLE:
  - On an edge with start=1, latch the operand magnitudes and both signs, and clear the error flags.
  - If divisor[N-2:0]==0: div_by_zero=1, quotient=0, remainder=0, go to FIN.
  - Else if dividend[2N-2:N-1] >= divisor[N-2:0]: overflow=1, quotient=0, remainder=0, go to FIN.
  - Otherwise: busy=1, iteration counter=N-1, partial remainder=dividend[2N-2:N-1], go to DIV.
- DIV (one iteration per cycle, N-1 iterations total):
  - Shift {partial remainder, dividend low bits} left by 1 and form the trial subtraction, using N bits for the partial remainder so no carry is lost.
  - If the trial is non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - Decrement the counter. After the last iteration go to FIN.
- FIN (one cycle):
  - done=1 and busy=0.
  - quotient = {qsign, qmag}, where qsign = dividend sign XOR divisor sign.
  - remainder = {rsign, rmag}, where rsign = dividend sign.
  - Any zero magnitude forces its sign bit to 0 (negative zero is never output).
  - Return to IDLE.
- Latency:
  - Normal division: done is high in the cycle after edge k+N, where k is the edge that sampled start.
  - Error cases: done is high after edge k+1.
- Holding and handshake:
  - quotient, remainder and the error flags hold their values until the next accepted start (start clears the flags).
  - start while busy or in FIN is ignored; no queueing.
  - start held high continuously restarts on every IDLE cycle.
  - Input operands are don't-care after the start edge.
- Negative-zero inputs are accepted: a negative-zero divisor is div_by_zero, and a negative-zero dividend gives a zero result.

Optional Feature:
- Macro: SM_DIV_OPCOUNT_EN.
- Defined: adds output op_count [7:0], reset 0. It increments on every done pulse, including error completions, and wraps 255 to 0.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- N=6, dividend 12'h064 (+100), divisor 6'h0D (+13), start 1 cycle -> done after 6 edges, quotient 6'h07, remainder 6'h09, busy high for 5 cycles, flags 0.
- dividend 12'h864 (-100), divisor 6'h0D -> quotient 6'h27 (-7), remainder 6'h29 (-9); with divisor 6'h2D and dividend 12'h064 -> quotient 6'h27, remainder 6'h09.
- divisor 6'h20 (-0), any dividend -> div_by_zero=1, overflow=0, quotient=remainder=0, done 1 cycle after start; dividend 12'h3E8 (+1000), divisor 6'h03 -> overflow=1, done 1 cycle after start.
- dividend 12'h800 (-0), divisor 6'h25 (-5) -> quotient 6'h00, remainder 6'h00 (sign normalised), no flags.
- Start +100/+13, assert start again with other operands in DIV cycle 2 -> ignored, result 7 r 9; then assert rst in DIV cycle 3 of a new op -> all outputs 0, no done, next start works normally.
- With SM_DIV_OPCOUNT_EN: 257 back-to-back divisions -> op_count reads 1 after the last one; without the macro, compile with no op_count port.
